// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: frames TX FIFO bytes onto an SPI master core with ss_n setup/hold; SPI_XFER_CTRL_RX_STALL_EN stalls on RX full instead of overflowing
module spi_xfer_ctrl #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int CS_DLY = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_wr_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    output logic       tx_full_o,
    input  logic       rx_rd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_empty_o,
    output logic       rx_ovf_o,
    output logic       busy_o,
    output logic       ss_n_o,
    output logic       spi_start_o,
    output logic [7:0] spi_din_o,
    input  logic       spi_ready_i,
    input  logic [7:0] spi_dout_i,
    input  logic       spi_done_tick_i
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int CW = $clog2(CS_DLY + 2);

    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, HOLD} state_t;
    state_t state, state_n;

    logic [8:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp, tx_wp_n, tx_rp_n;
    logic [RAW:0] rx_wp, rx_rp, rx_wp_n, rx_rp_n;
    logic [CW-1:0] cnt, cnt_n;
    logic tx_pend, tx_empty, tx_push, tx_pop, rx_push, rx_pop, rx_full;
    logic can_issue, ovf_set, last, last_n, ss_n_n;

    assign tx_empty = tx_wp == tx_rp;
    assign tx_push = tx_wr_i && !tx_full_o;
    assign rx_pop = rx_rd_i && !rx_empty_o;
    assign rx_full = (rx_wp - rx_rp) == (RAW + 1)'(RX_DEPTH);
`ifdef SPI_XFER_CTRL_RX_STALL_EN
    assign can_issue = !tx_empty && spi_ready_i && !rx_full;
    assign rx_push = state == WAIT && spi_done_tick_i;
    assign ovf_set = 1'b0;
`else
    assign can_issue = !tx_empty && spi_ready_i;
    assign rx_push = state == WAIT && spi_done_tick_i && (!rx_full || rx_pop);
    assign ovf_set = state == WAIT && spi_done_tick_i && rx_full && !rx_pop;
`endif
    assign tx_pop = state == ISSUE && can_issue;
    assign tx_wp_n = tx_wp + (TAW + 1)'(tx_push);
    assign tx_rp_n = tx_rp + (TAW + 1)'(tx_pop);
    assign rx_wp_n = rx_wp + (RAW + 1)'(rx_push);
    assign rx_rp_n = rx_rp + (RAW + 1)'(rx_pop);

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        last_n = last;
        ss_n_n = ss_n_o;
        case (state)
            IDLE: if (tx_pend) begin
                state_n = SETUP;
                cnt_n = CW'(CS_DLY);
                ss_n_n = 1'b0;
            end
            SETUP: begin
                cnt_n = cnt - CW'(1);
                if (cnt <= CW'(1)) state_n = ISSUE;
            end
            ISSUE: if (can_issue) begin
                state_n = WAIT;
                last_n = tx_mem[tx_rp[TAW-1:0]][8];
            end
            WAIT: if (spi_done_tick_i) begin
                state_n = last ? HOLD : ISSUE;
                cnt_n = CW'(CS_DLY);
            end
            HOLD: begin
                cnt_n = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    state_n = IDLE;
                    ss_n_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx_pend lags the pointers by a cycle so a burst of pushes lands before ss_n falls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            last <= 1'b0;
            ss_n_o <= 1'b1;
            spi_start_o <= 1'b0;
            spi_din_o <= '0;
            busy_o <= 1'b0;
            rx_ovf_o <= 1'b0;
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            tx_pend <= 1'b0;
            tx_full_o <= 1'b0;
            rx_empty_o <= 1'b1;
            rx_data_o <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            last <= last_n;
            ss_n_o <= ss_n_n;
            spi_start_o <= tx_pop;
            if (tx_pop) spi_din_o <= tx_mem[tx_rp[TAW-1:0]][7:0];
            busy_o <= state_n != IDLE;
            rx_ovf_o <= rx_ovf_o | ovf_set;
            tx_wp <= tx_wp_n;
            tx_rp <= tx_rp_n;
            rx_wp <= rx_wp_n;
            rx_rp <= rx_rp_n;
            tx_pend <= !tx_empty;
            tx_full_o <= (tx_wp_n - tx_rp_n) == (TAW + 1)'(TX_DEPTH);
            rx_empty_o <= rx_wp_n == rx_rp_n;
            rx_data_o <= (rx_push && rx_rp_n == rx_wp) ? spi_dout_i : rx_mem[rx_rp_n[RAW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= {tx_last_i, tx_data_i};
        if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= spi_dout_i;
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: randomized bench with an SPI core model and queue-based reference for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
    localparam int CS_DLY = 4;
    localparam int DEPTH = 16;
    localparam int BUDGET = 3000;

    logic clk_i = 1'b0;
    logic rst_i, tx_wr_i, tx_last_i, rx_rd_i, spi_ready_i, spi_done_tick_i;
    logic [7:0] tx_data_i, spi_dout_i, rx_data_o, spi_din_o;
    logic tx_full_o, rx_empty_o, rx_ovf_o, busy_o, ss_n_o, spi_start_o;
    int tests = 0, fails = 0;
    int ss_fall = 0, ss_rise = 0, bad_start = 0;
    time push_t, fall_t, rise_t, start_t, done_t;
    bit core_hold = 0, done_pend = 0;
    logic [7:0] sent_q[$], reply_q[$];
    int gap_q[$];

    always #5 clk_i = ~clk_i;

    spi_xfer_ctrl #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .CS_DLY(CS_DLY)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .tx_wr_i(tx_wr_i), .tx_data_i(tx_data_i), .tx_last_i(tx_last_i), .tx_full_o(tx_full_o),
        .rx_rd_i(rx_rd_i), .rx_data_o(rx_data_o), .rx_empty_o(rx_empty_o), .rx_ovf_o(rx_ovf_o),
        .busy_o(busy_o), .ss_n_o(ss_n_o), .spi_start_o(spi_start_o), .spi_din_o(spi_din_o),
        .spi_ready_i(spi_ready_i), .spi_dout_i(spi_dout_i), .spi_done_tick_i(spi_done_tick_i)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // SPI core model plus ss_n/start monitor, all sampled on the falling edge
    initial begin
        bit prev_ss = 1'b1;
        bit cbusy = 1'b0;
        int lat = 0;
        spi_ready_i = 1'b1;
        spi_done_tick_i = 1'b0;
        spi_dout_i = '0;
        forever begin
            @(negedge clk_i);
            spi_done_tick_i = 1'b0;
            if (prev_ss != ss_n_o) begin
                if (ss_n_o) begin
                    ss_rise++;
                    rise_t = $time;
                end else begin
                    ss_fall++;
                    fall_t = $time;
                end
                done_pend = 1'b0;
            end
            prev_ss = ss_n_o;
            if (cbusy && spi_din_o != sent_q[$]) bad_start++;
            if (spi_start_o) begin
                if (ss_n_o || cbusy) bad_start++;
                sent_q.push_back(spi_din_o);
                start_t = $time;
                if (done_pend) gap_q.push_back(int'($time - done_t));
                done_pend = 1'b0;
                cbusy = 1'b1;
                lat = $urandom_range(2, 6);
            end else if (cbusy) begin
                lat--;
                if (lat == 0) begin
                    spi_dout_i = 8'($urandom);
                    spi_done_tick_i = 1'b1;
                    reply_q.push_back(spi_dout_i);
                    done_t = $time;
                    done_pend = 1'b1;
                    cbusy = 1'b0;
                end
            end
            spi_ready_i = !cbusy && !core_hold;
        end
    end

    task automatic push(input logic [7:0] d, input logic l);
        tx_data_i = d;
        tx_last_i = l;
        tx_wr_i = 1'b1;
        push_t = $time;
        @(negedge clk_i);
        tx_wr_i = 1'b0;
    endtask

    task automatic push_fc(input logic [7:0] d, input logic l);
        int k = 0;
        while (tx_full_o && k < BUDGET) begin
            @(negedge clk_i);
            k++;
        end
        check("push_wait", k < BUDGET, 1);
        push(d, l);
    endtask

    task automatic wait_cnt(input string tag, input int n);
        int k = 0;
        while (sent_q.size() < n && k < BUDGET) begin
            @(negedge clk_i);
            k++;
        end
        check({tag, "_start_wait"}, k < BUDGET, 1);
    endtask

    task automatic wait_starts(input string tag, input int n);
        int k = 0;
        while ((sent_q.size() < n || busy_o) && k < BUDGET) begin
            @(negedge clk_i);
            k++;
        end
        check({tag, "_frame_wait"}, k < BUDGET, 1);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic drain(input string tag, input int r0, input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            int k = 0;
            while (rx_empty_o && k < BUDGET) begin
                @(negedge clk_i);
                k++;
            end
            check($sformatf("%s_rx_wait%0d", tag, i), k < BUDGET, 1);
            d = rx_data_o;
            rx_rd_i = 1'b1;
            @(negedge clk_i);
            rx_rd_i = 1'b0;
            check($sformatf("%s_rx%0d", tag, i), d, reply_q[r0 + i]);
        end
        check({tag, "_rx_empty"}, rx_empty_o, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] frame[$];
        logic [7:0] tx_b[17];
        int s0, s1, r0, f0, rr0, g0, b0, len;
        rst_i = 1'b1;
        tx_wr_i = 1'b0;
        tx_last_i = 1'b0;
        tx_data_i = '0;
        rx_rd_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_ss_n", ss_n_o, 1);
        check("rst_start", spi_start_o, 0);
        check("rst_din", spi_din_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", rx_ovf_o, 0);
        check("rst_tx_full", tx_full_o, 0);
        check("rst_rx_empty", rx_empty_o, 1);
        check("rst_rx_data", rx_data_o, 0);
        b0 = bad_start;

        s0 = sent_q.size(); r0 = reply_q.size(); f0 = ss_fall;
        push(8'hAA, 1'b1);
        wait_starts("single", s0 + 1);
        check("single_count", sent_q.size() - s0, 1);
        check("single_din", sent_q[s0], 8'hAA);
        check("single_ss_setup", 32'(fall_t - push_t), 30);
        check("single_start_dly", 32'(start_t - push_t), (CS_DLY + 4) * 10);
        check("single_ss_hold", 32'(rise_t - done_t), (CS_DLY + 1) * 10);
        check("single_frames", ss_fall - f0, 1);
        check("single_busy", busy_o, 0);
        check("single_ss_n", ss_n_o, 1);
        drain("single", r0, 1);

        s0 = sent_q.size(); r0 = reply_q.size(); f0 = ss_fall; rr0 = ss_rise; g0 = gap_q.size();
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b1);
        wait_starts("three", s0 + 3);
        for (int i = 0; i < 3; i++) check($sformatf("three_din%0d", i), sent_q[s0 + i], i + 1);
        check("three_frames", ss_fall - f0, 1);
        check("three_rises", ss_rise - rr0, 1);
        check("three_gaps", gap_q.size() - g0, 2);
        for (int i = g0; i < gap_q.size(); i++) check("three_b2b_gap", gap_q[i], 20);
        drain("three", r0, 3);

        s0 = sent_q.size(); r0 = reply_q.size(); f0 = ss_fall; rr0 = ss_rise;
        push(8'h10, 1'b0);
        wait_cnt("under_first", s0 + 1);
        repeat (50) @(negedge clk_i);
        check("under_ss_low", ss_n_o, 0);
        check("under_no_rise", ss_rise - rr0, 0);
        check("under_busy", busy_o, 1);
        push(8'h11, 1'b1);
        wait_cnt("under_second", s0 + 2);
        check("under_start_dly", 32'(start_t - push_t), 20);
        wait_starts("under", s0 + 2);
        check("under_din0", sent_q[s0], 8'h10);
        check("under_din1", sent_q[s0 + 1], 8'h11);
        check("under_frames", ss_fall - f0, 1);
        drain("under", r0, 2);

        core_hold = 1'b1;
        s0 = sent_q.size(); r0 = reply_q.size();
        for (int i = 0; i < 17; i++) begin
            tx_b[i] = 8'($urandom);
            push(tx_b[i], i >= 15);
            if (i == 14) check("txfull_at15", tx_full_o, 0);
            if (i == 15) check("txfull_at16", tx_full_o, 1);
        end
        check("txfull_after17", tx_full_o, 1);
        check("txfull_held", sent_q.size() - s0, 0);
        core_hold = 1'b0;
        wait_starts("txfull", s0 + 16);
        repeat (20) @(negedge clk_i);
        check("txfull_count", sent_q.size() - s0, 16);
        check("txfull_clear", tx_full_o, 0);
        for (int i = 0; i < 16; i++) check($sformatf("txfull_din%0d", i), sent_q[s0 + i], tx_b[i]);
        check("txfull_ovf", rx_ovf_o, 0);
        drain("txfull", r0, 16);

        s0 = sent_q.size(); r0 = reply_q.size();
        frame.delete();
        for (int i = 0; i < 20; i++) begin
            frame.push_back(8'($urandom));
            push_fc(frame[i], i == 19);
        end
`ifdef SPI_XFER_CTRL_RX_STALL_EN
        wait_cnt("rxfull_16", s0 + 16);
        repeat (40) @(negedge clk_i);
        check("rxfull_stalled", sent_q.size() - s0, 16);
        check("rxfull_ss_low", ss_n_o, 0);
        drain("rxfull", r0, 20);
        wait_starts("rxfull", s0 + 20);
        check("rxfull_ovf", rx_ovf_o, 0);
`else
        wait_starts("rxfull", s0 + 20);
        check("rxfull_ovf", rx_ovf_o, 1);
        drain("rxfull", r0, 16);
        check("rxfull_ovf_sticky", rx_ovf_o, 1);
`endif
        check("rxfull_count", sent_q.size() - s0, 20);
        for (int i = 0; i < 20; i++) check($sformatf("rxfull_din%0d", i), sent_q[s0 + i], frame[i]);

        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 6);
            s0 = sent_q.size(); r0 = reply_q.size(); f0 = ss_fall;
            frame.delete();
            for (int i = 0; i < len; i++) begin
                frame.push_back(8'($urandom));
                push_fc(frame[i], i == len - 1);
                if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 8)) @(negedge clk_i);
            end
            wait_starts($sformatf("rand%0d", f), s0 + len);
            check($sformatf("rand%0d_count", f), sent_q.size() - s0, len);
            for (int i = 0; i < len; i++) check($sformatf("rand%0d_din%0d", f, i), sent_q[s0 + i], frame[i]);
            check($sformatf("rand%0d_frames", f), ss_fall - f0, 1);
            drain($sformatf("rand%0d", f), r0, len);
        end
        check("start_framing", bad_start - b0, 0);

        s0 = sent_q.size();
        push(8'h31, 1'b0);
        push(8'h32, 1'b0);
        push(8'h33, 1'b0);
        push(8'h34, 1'b1);
        wait_cnt("rstmid_b2", s0 + 2);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rstmid_ss_n", ss_n_o, 1);
        check("rstmid_start", spi_start_o, 0);
        check("rstmid_rx_empty", rx_empty_o, 1);
        check("rstmid_tx_full", tx_full_o, 0);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_ovf", rx_ovf_o, 0);
        rst_i = 1'b0;
        s1 = sent_q.size();
        repeat (40) @(negedge clk_i);
        check("rstmid_no_start", sent_q.size() - s1, 0);
        check("rstmid_rx_still_empty", rx_empty_o, 1);
        check("rstmid_ss_idle", ss_n_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- Transaction controller directly upstream of the SPI master core.
- Buffers outgoing bytes in a TX FIFO and drives the core's start/din handshake byte by byte, with slave-select (ss_n) framing.
- Collects each received byte into an RX FIFO on the core's done tick.
- The host pushes a multi-byte frame once; the controller runs it to completion without per-byte host intervention.

Parameters:
- TX_DEPTH, 16, TX FIFO entries (power of 2, >=2); each entry is {last, data[7:0]}.
- RX_DEPTH, 16, RX FIFO entries (power of 2, >=2); each entry is data[7:0].
- CS_DLY, 4, clk_i cycles of ss_n setup before the first start and hold after the last done tick.

Ports:
- clk_i  in  1  system clock, shared with the SPI master core.
- rst_i  in  1  synchronous, active-high reset.
- tx_wr_i  in  1  push strobe into the TX FIFO.
- tx_data_i  in  8  byte to transmit.
- tx_last_i  in  1  byte ends the frame; ss_n deasserts after it.
- tx_full_o  out  1  TX FIFO full.
- rx_rd_i  in  1  pop strobe from the RX FIFO.
- rx_data_o  out  8  RX FIFO head (first-word fall-through).
- rx_empty_o  out  1  RX FIFO empty.
- rx_ovf_o  out  1  sticky RX overflow flag.
- busy_o  out  1  frame in progress (state != IDLE).
- ss_n_o  out  1  active-low slave select.
- spi_start_o  out  1  one-cycle start pulse to the SPI master core.
- spi_din_o  out  8  byte presented to the core; held stable from start until the done tick.
- spi_ready_i  in  1  SPI master core idle.
- spi_dout_i  in  8  byte received by the core; valid with the done tick.
- spi_done_tick_i  in  1  one-cycle pulse at the end of each byte.

Behaviour:
- Reset values:
  - ss_n_o=1; spi_start_o=0; spi_din_o=0; busy_o=0; rx_ovf_o=0.
  - Both FIFOs empty: tx_full_o=0, rx_empty_o=1, rx_data_o=0.
  - FSM goes to IDLE.
- Reset mid-frame: aborts the frame immediately; ss_n_o=1 on the cycle after reset is sampled; all FIFO contents are discarded.
- TX push: tx_wr_i with tx_full_o=0 writes {tx_last_i, tx_data_i}.
  - A write while full is dropped silently.
  - tx_full_o reflects the pre-pop state, so a push and pop in the same cycle while full drops the push.
- RX pop: rx_rd_i with rx_empty_o=0 advances the head; a pop while empty is ignored.
  - A simultaneous push and pop on a full RX FIFO succeeds, and the count is unchanged.
- All outputs are registered. FIFO pointers are log2(DEPTH)+1 bits wide so full and empty are unambiguous at wrap-around.
- FSM states:
  - IDLE: ss_n_o=1. If the TX FIFO is not empty: ss_n_o<=0, load cnt=CS_DLY, go to SETUP.
  - SETUP: decrement cnt; at cnt==0 go to ISSUE. Minimum dwell is 1 cycle, even with CS_DLY=0.
  - ISSUE: wait until the TX FIFO is not empty and spi_ready_i=1, then:
    - spi_start_o<=1 for exactly 1 cycle;
    - spi_din_o<=head data;
    - pop TX and latch the last flag;
    - go to WAIT.
    - If the TX FIFO is empty without a last byte seen, stay in ISSUE with ss_n_o held low.
  - WAIT: on spi_done_tick_i:
    - push spi_dout_i to RX;
    - if last: load cnt=CS_DLY and go to HOLD;
    - otherwise go to ISSUE.
  - HOLD: decrement cnt; at cnt==0: ss_n_o<=1, go to IDLE.
- Timing from an IDLE push at edge N: ss_n_o low after edge N+2; first spi_start_o after edge N+2+max(CS_DLY,1)+1.
- Back-to-back bytes: the next start issues 1 cycle after the done tick, provided TX is not empty.
- An RX push while full is handled by the optional feature (below).
- A spi_done_tick_i outside WAIT is ignored.
- A frame ends only on a byte with last=1. There is no timeout.

Optional Feature:
- Macro: SPI_XFER_CTRL_RX_STALL_EN.
- Defined:
  - ISSUE additionally requires the RX FIFO not full before starting a byte, so no received byte is ever lost.
  - rx_ovf_o stays 0.
- Undefined:
  - ISSUE ignores RX occupancy.
  - A done tick with the RX FIFO full discards spi_dout_i and sets rx_ovf_o=1.
  - rx_ovf_o is cleared only by rst_i.

Test Plan:
- Single byte: push 0xAA with last=1, CS_DLY=4, and a core model returning 0x23 -> ss_n_o falls, one spi_start_o with spi_din_o=0xAA, ss_n_o rises 4+ cycles after the done tick, rx_data_o=0x23, busy_o back to 0.
- Three-byte frame: push 0x01, 0x02, 0x03 (last on 0x03) -> three start pulses in order, ss_n_o low continuously across the frame, RX holds the three core replies in order.
- TX underrun mid-frame: push 0x10 (last=0), wait 50 cycles, then push 0x11 (last=1) -> ss_n_o stays low throughout, second start issues within 1 cycle of the push.
- TX full: push 17 bytes with TX_DEPTH=16 while spi_ready_i=0 -> tx_full_o=1 after 16 pushes, 17th dropped, exactly 16 bytes transmitted once ready rises.
- RX full: 20-byte frame with no RX pops -> macro defined: stalls after 16 bytes, resumes on a pop; macro undefined: 4 bytes dropped, rx_ovf_o=1.
- Reset mid-frame: assert rst_i during WAIT of byte 2 of 4 -> ss_n_o=1 next cycle, rx_empty_o=1, tx_full_o=0, no further spi_start_o.
